// File: rtl/imem_iwb_lsu.sv
// MEM-stage load/store unit: classifies the EX/MEM access, runs the dmem req/ready
// handshake with timeout, aligns stores, extends loads and registers the MEM/WB stage.
module imem_iwb_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validm,
    input  logic        memreadm,
    input  logic        memwritem,
    input  logic [2:0]  funct3m,
    input  logic [31:0] aluresulm,
    input  logic [31:0] writedatm,
    input  logic [4:0]  rdm,
    input  logic [31:0] pcplus4m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stallm,
    output logic        validw,
    output logic [31:0] aluresultw,
    output logic [31:0] readdataw,
    output logic [4:0]  rdw,
    output logic [31:0] pcplus4w,
    output logic        excw,
    output logic [1:0]  exccausew
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CAU_W = 2;

    localparam logic [CAU_W-1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [CAU_W-1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [CAU_W-1:0] CAUSE_ILLEGAL  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // MEM/WB pipeline register payload
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  rdata;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  pc4;
        logic             exc;
        logic [CAU_W-1:0] cause;
    } wb_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    wb_t              wb_q, wb_d;

    logic             memop, ld_bad, st_bad, illegal, misaligned, size_bad;
    logic [1:0]       off;
    logic [XLEN-1:0]  wdata_c;
    logic [3:0]       be_st_c;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_data_c;
    logic             req_c, stall_c;
    wb_t              done_c, exc_c;

    // Access classification
    always_comb begin
        memop  = memreadm | memwritem;
        off    = aluresulm[1:0];
        ld_bad = memreadm && (funct3m == 3'b011 || funct3m == 3'b110 || funct3m == 3'b111);
        st_bad = memwritem && !(funct3m == 3'b000 || funct3m == 3'b001 || funct3m == 3'b010);
        illegal = validm && ((memreadm && memwritem) || ld_bad || st_bad);
        case (funct3m[1:0])
            2'b01:   size_bad = off[0];
            2'b10:   size_bad = (off != 2'b00);
            default: size_bad = 1'b0;
        endcase
        misaligned = validm && memop && !illegal && size_bad;
    end

    // Store lane replication and byte enables
    always_comb begin
        case (funct3m[1:0])
            2'b00: begin
                wdata_c = {4{writedatm[7:0]}};
                be_st_c = 4'(4'b0001 << off);
            end
            2'b01: begin
                wdata_c = {2{writedatm[15:0]}};
                be_st_c = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_c = writedatm;
                be_st_c = 4'b1111;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        ld_byte = dmem_rdata[{off, 3'b000} +: 8];
        ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];
        case (funct3m)
            3'b000:  ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data_c = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data_c = {24'h0, ld_byte};
            3'b101:  ld_data_c = {16'h0, ld_half};
            default: ld_data_c = dmem_rdata;
        endcase
        if (!memreadm) begin
            ld_data_c = '0;
        end
    end

    // Candidate W-stage payloads for a normal completion and an exception
    always_comb begin
        done_c       = '0;
        done_c.valid = 1'b1;
        done_c.alu   = aluresulm;
        done_c.rdata = ld_data_c;
        done_c.rd    = rdm;
        done_c.pc4   = pcplus4m;
        exc_c        = '0;
        exc_c.valid  = 1'b1;
        exc_c.alu    = aluresulm;
        exc_c.pc4    = pcplus4m;
        exc_c.exc    = 1'b1;
        exc_c.cause  = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
    end

    // Next-state and handshake control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wb_d    = '0;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!validm) begin
                    wb_d = '0;
                end else if (illegal || misaligned) begin
                    wb_d = exc_c;
                end else if (!memop) begin
                    wb_d = done_c;
                end else begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        wb_d = done_c;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (dmem_ready) begin
                    stall_c = 1'b0;
                    wb_d    = done_c;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stall_c     = 1'b0;
                    wb_d        = exc_c;
                    wb_d.cause  = CAUSE_TIMEOUT;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    // Reset gates the request and stall immediately
    assign dmem_req   = req_c & reset;
    assign stallm     = stall_c & reset;
    assign dmem_we    = dmem_req & memwritem;
    assign dmem_be    = dmem_req ? (memwritem ? be_st_c : 4'b1111) : 4'b0000;
    assign dmem_addr  = {aluresulm[31:2], 2'b00};
    assign dmem_wdata = wdata_c;

    assign validw     = wb_q.valid;
    assign aluresultw = wb_q.alu;
    assign readdataw  = wb_q.rdata;
    assign rdw        = wb_q.rd;
    assign pcplus4w   = wb_q.pc4;
    assign excw       = wb_q.exc;
    assign exccausew  = wb_q.cause;

endmodule

// File: tb/tb_imem_iwb_lsu.sv
// Directed bench for imem_iwb_lsu: reset, ALU pass-through, store lanes, load
// extension, exceptions, timeout, back-to-back and reset during a pending access.
module tb_imem_iwb_lsu;

    logic        clk;
    logic        reset;
    logic        validm, memreadm, memwritem;
    logic [2:0]  funct3m;
    logic [31:0] aluresulm, writedatm, pcplus4m;
    logic [4:0]  rdm;
    logic        dmem_req, dmem_we, dmem_ready, stallm;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        validw, excw;
    logic [31:0] aluresultw, readdataw, pcplus4w;
    logic [4:0]  rdw;
    logic [1:0]  exccausew;

    int errors = 0;
    int checks = 0;

    imem_iwb_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .validm(validm), .memreadm(memreadm),
        .memwritem(memwritem), .funct3m(funct3m), .aluresulm(aluresulm),
        .writedatm(writedatm), .rdm(rdm), .pcplus4m(pcplus4m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stallm(stallm), .validw(validw),
        .aluresultw(aluresultw), .readdataw(readdataw), .rdw(rdw),
        .pcplus4w(pcplus4w), .excw(excw), .exccausew(exccausew)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        validm = 0; memreadm = 0; memwritem = 0; funct3m = 3'b000;
        aluresulm = 0; writedatm = 0; rdm = 0; pcplus4m = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_in();
        dmem_rdata = 32'h0;
        validm = 1; memreadm = 1; funct3m = 3'b010; aluresulm = 32'h100; rdm = 5;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_req); end
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stallm); end
        step(); step();
        checks++;
        if ({validw, aluresultw, readdataw, rdw, pcplus4w, excw, exccausew} !== '0) begin
            errors++;
            $display("FAIL rst_w: got v=%b alu=%h rd=%h rdw=%0d pc=%h exc=%b c=%b want all 0",
                     validw, aluresultw, readdataw, rdw, pcplus4w, excw, exccausew);
        end
        idle_in();
        reset = 1;
        step();
    endtask

    task automatic test_alu();
        validm = 1; aluresulm = 32'h0000ABCD; rdm = 13; pcplus4m = 32'h00400004;
        #1;
        checks++; if (stallm !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL alu_stall: got stall=%b req=%b want 0 0", stallm, dmem_req); end
        step();
        checks++; if (aluresultw !== 32'h0000ABCD) begin errors++; $display("FAIL alu_res: got %h want 0000abcd", aluresultw); end
        checks++; if (rdw !== 5'd13 || pcplus4w !== 32'h00400004) begin errors++; $display("FAIL alu_rd_pc: got %0d %h want 13 00400004", rdw, pcplus4w); end
        checks++; if (validw !== 1'b1 || excw !== 1'b0 || readdataw !== 32'h0) begin errors++; $display("FAIL alu_flags: got v=%b exc=%b rd=%h want 1 0 0", validw, excw, readdataw); end
        idle_in();
        step();
        checks++; if (validw !== 1'b0) begin errors++; $display("FAIL bubble: got %b want 0", validw); end
    endtask

    task automatic test_sb_wait();
        int stalls = 0;
        bit done = 0;
        validm = 1; memwritem = 1; funct3m = 3'b000; aluresulm = 32'h00001003;
        writedatm = 32'hDEADBEEF; rdm = 7; pcplus4m = 32'h10;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            dmem_ready = (cyc == 3);
            #1;
            if (cyc == 0) begin
                checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sb_req: got req=%b we=%b want 1 1", dmem_req, dmem_we); end
                checks++; if (dmem_addr !== 32'h00001000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", dmem_addr); end
                checks++; if (dmem_be !== 4'b1000 || dmem_wdata !== 32'hEFEFEFEF) begin errors++; $display("FAIL sb_lane: got be=%b wd=%h want 1000 efefefef", dmem_be, dmem_wdata); end
            end
            if (cyc == 2) begin
                checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_hold: got req=%b be=%b want 1 1000", dmem_req, dmem_be); end
            end
            if (stallm) stalls++;
            done = !stallm;
            step();
        end
        checks++; if (!done) begin errors++; $display("FAIL sb_done: got no completion want completion in 40 cycles"); end
        checks++; if (stalls != 3) begin errors++; $display("FAIL sb_stalls: got %0d want 3", stalls); end
        checks++; if (validw !== 1'b1 || rdw !== 5'd7 || readdataw !== 32'h0 || excw !== 1'b0) begin errors++; $display("FAIL sb_w: got v=%b rd=%0d data=%h exc=%b want 1 7 0 0", validw, rdw, readdataw, excw); end
        idle_in();
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3 [3] = '{3'b001, 3'b001, 3'b010};
        logic [31:0] ad [3] = '{32'h2002, 32'h2000, 32'h2004};
        logic [31:0] ew [3] = '{32'hABCDABCD, 32'hABCDABCD, 32'h1234ABCD};
        logic [3:0]  eb [3] = '{4'b1100, 4'b0011, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            validm = 1; memwritem = 1; funct3m = f3[i]; aluresulm = ad[i];
            writedatm = 32'h1234ABCD; rdm = 3; dmem_ready = 1;
            #1;
            checks++; if (dmem_be !== eb[i] || dmem_wdata !== ew[i] || stallm !== 1'b0) begin errors++; $display("FAIL st_lane%0d: got be=%b wd=%h st=%b want %b %h 0", i, dmem_be, dmem_wdata, stallm, eb[i], ew[i]); end
            step();
            checks++; if (validw !== 1'b1 || excw !== 1'b0) begin errors++; $display("FAIL st_done%0d: got v=%b exc=%b want 1 0", i, validw, excw); end
        end
        idle_in();
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad [6] = '{32'h5002, 32'h5002, 32'h5000, 32'h5002, 32'h5002, 32'h5000};
        logic [31:0] ex [6] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFFF2F3,
                                32'hFFFF8081, 32'h00008081, 32'h8081F2F3};
        int          dl [6] = '{1, 2, 1, 0, 1, 0};
        dmem_rdata = 32'h8081F2F3;
        for (int i = 0; i < 6; i++) begin
            int stalls = 0;
            bit done = 0;
            validm = 1; memreadm = 1; funct3m = f3[i]; aluresulm = ad[i]; rdm = 5'(10 + i);
            for (int cyc = 0; cyc < 20 && !done; cyc++) begin
                dmem_ready = (cyc == dl[i]);
                #1;
                if (cyc == 0) begin
                    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'b1111) begin errors++; $display("FAIL ld_req%0d: got req=%b we=%b be=%b want 1 0 1111", i, dmem_req, dmem_we, dmem_be); end
                end
                if (stallm) stalls++;
                done = !stallm;
                step();
            end
            checks++; if (!done || stalls != dl[i]) begin errors++; $display("FAIL ld_stall%0d: got done=%b stalls=%0d want 1 %0d", i, done, stalls, dl[i]); end
            checks++; if (readdataw !== ex[i] || validw !== 1'b1 || rdw !== 5'(10 + i)) begin errors++; $display("FAIL ld_data%0d: got %h v=%b rd=%0d want %h 1 %0d", i, readdataw, validw, rdw, ex[i], 10 + i); end
        end
        idle_in();
    endtask

    task automatic test_exceptions();
        logic       rd_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       wr_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] f3   [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad  [5] = '{32'h2002, 32'h2001, 32'h2000, 32'h2000, 32'h2000};
        logic [1:0] ec   [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            validm = 1; memreadm = rd_v[i]; memwritem = wr_v[i]; funct3m = f3[i];
            aluresulm = ad[i]; rdm = 9; dmem_ready = 1;
            #1;
            checks++; if (dmem_req !== 1'b0 || stallm !== 1'b0 || dmem_be !== 4'b0) begin errors++; $display("FAIL exc_req%0d: got req=%b st=%b be=%b want 0 0 0000", i, dmem_req, stallm, dmem_be); end
            step();
            checks++; if (excw !== 1'b1 || exccausew !== ec[i] || rdw !== 5'd0 || validw !== 1'b1) begin errors++; $display("FAIL exc_w%0d: got exc=%b c=%b rd=%0d v=%b want 1 %b 0 1", i, excw, exccausew, rdw, validw, ec[i]); end
        end
        idle_in();
    endtask

    task automatic test_timeout();
        int stalls = 0;
        int reqs = 0;
        bit done = 0;
        validm = 1; memreadm = 1; funct3m = 3'b010; aluresulm = 32'h3000; rdm = 4;
        dmem_ready = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (stallm) stalls++;
            if (dmem_req) reqs++;
            done = !stallm;
            step();
        end
        checks++; if (!done) begin errors++; $display("FAIL to_done: got no completion want timeout"); end
        checks++; if (stalls != 16 || reqs != 17) begin errors++; $display("FAIL to_count: got stalls=%0d reqs=%0d want 16 17", stalls, reqs); end
        checks++; if (excw !== 1'b1 || exccausew !== 2'b10 || rdw !== 5'd0 || validw !== 1'b1) begin errors++; $display("FAIL to_w: got exc=%b c=%b rd=%0d v=%b want 1 10 0 1", excw, exccausew, rdw, validw); end
        idle_in();
        #1;
        checks++; if (dmem_req !== 1'b0 || stallm !== 1'b0) begin errors++; $display("FAIL to_drop: got req=%b st=%b want 0 0", dmem_req, stallm); end
        step();
    endtask

    task automatic test_back_to_back();
        validm = 1; memreadm = 1; funct3m = 3'b010; aluresulm = 32'h6000; rdm = 20;
        dmem_rdata = 32'hCAFEF00D; dmem_ready = 0;
        #1; step();
        dmem_ready = 1;
        #1;
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b want 0", stallm); end
        step();
        checks++; if (readdataw !== 32'hCAFEF00D || validw !== 1'b1) begin errors++; $display("FAIL b2b_ld: got %h v=%b want cafef00d 1", readdataw, validw); end
        memreadm = 0; memwritem = 1; funct3m = 3'b000; aluresulm = 32'h6001;
        writedatm = 32'h000000A5; rdm = 21; dmem_ready = 1;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_sb: got req=%b be=%b wd=%h want 1 0010 a5a5a5a5", dmem_req, dmem_be, dmem_wdata); end
        step();
        memwritem = 0; aluresulm = 32'h77; rdm = 22; dmem_ready = 0;
        #1;
        checks++; if (rdw !== 5'd21 || validw !== 1'b1 || stallm !== 1'b0) begin errors++; $display("FAIL b2b_st_w: got rd=%0d v=%b st=%b want 21 1 0", rdw, validw, stallm); end
        step();
        checks++; if (aluresultw !== 32'h77 || rdw !== 5'd22) begin errors++; $display("FAIL b2b_alu: got %h rd=%0d want 00000077 22", aluresultw, rdw); end
        idle_in();
    endtask

    task automatic test_reset_in_wait();
        validm = 1; memwritem = 1; funct3m = 3'b010; aluresulm = 32'h4000;
        writedatm = 32'h11223344; rdm = 8; dmem_ready = 0;
        #1; step(); step(); step();
        reset = 0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stallm !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL rw_force: got req=%b st=%b we=%b want 0 0 0", dmem_req, stallm, dmem_we); end
        step();
        checks++; if ({validw, aluresultw, readdataw, rdw, pcplus4w, excw, exccausew} !== '0) begin errors++; $display("FAIL rw_w: got v=%b alu=%h rd=%0d want all 0", validw, aluresultw, rdw); end
        reset = 1;
        idle_in();
        dmem_ready = 1;
        #1;
        checks++; if (dmem_req !== 1'b0 || stallm !== 1'b0) begin errors++; $display("FAIL rw_idle: got req=%b st=%b want 0 0", dmem_req, stallm); end
        step();
        checks++; if (validw !== 1'b0 || excw !== 1'b0) begin errors++; $display("FAIL rw_ready: got v=%b exc=%b want 0 0", validw, excw); end
        dmem_ready = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sb_wait();
        test_store_lanes();
        test_loads();
        test_exceptions();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
